fpu_addsub_pipe: RTL and testbench

Parametrised, pipelined floating-point adder/subtractor with a valid/ready handshake. It generalises the half-precision combinational add/sub path (sorter, aligner, LZC, normaliser) to any IEEE-754 binary format of `EXPW`/`FRACW`. It adds full special-value handling, subnormal inputs and outputs, two rounding modes and a three-stage pipeline. It sits between the FPU operand issue logic and the result writeback arbiter.

---
 rtl/fpu_addsub_pipe.sv | 216 +++++++++++++++++++++
 tb/tb_fpu_addsub_pipe.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_addsub_pipe.sv
// Three-stage IEEE-754 binary add/sub with full special-value, subnormal and RNE/RTZ handling.
// One global stall (advance) holds every stage while the output waits on outReady.
module fpu_addsub_pipe #(
   parameter int EXPW  = 5,
   parameter int FRACW = 10,
   parameter int W     = 1 + EXPW + FRACW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         inValid,
   output logic         inReady,
   input  logic [W-1:0] fpuIn1,
   input  logic [W-1:0] fpuIn2,
   input  logic         op,
   input  logic         rndMode,
   output logic         outValid,
   input  logic         outReady,
   output logic [W-1:0] result,
   output logic [4:0]   statusFlags
);
   localparam int D  = FRACW + 4;
   localparam int EW = EXPW + 1;
   localparam logic [EXPW-1:0] EXP_ONES = '1;
   localparam logic [EXPW-1:0] EXP_MAXF = EXP_ONES - EXPW'(1);
   localparam logic [W-1:0]    QNAN     = {1'b0, EXP_ONES, 1'b1, {(FRACW-1){1'b0}}};

   function automatic logic [D-1:0] align_f(input logic [D-1:0] sig, input logic [EXPW-1:0] sh);
      logic [2*D-1:0] wide;
      if (32'(sh) >= FRACW + 3) return {{(D-1){1'b0}}, |sig};
      wide = {sig, {D{1'b0}}} >> sh;
      return {wide[2*D-1:D+1], wide[D] | (|wide[D-1:0])};
   endfunction

   function automatic int unsigned lzc_f(input logic [D-1:0] v);
      int unsigned n;
      n = D;
      for (int i = 0; i < D; i++)
         if (v[i]) n = D - 1 - i;
      return n;
   endfunction

   function automatic logic [FRACW+1:0] round_f(input logic [D-1:0] m, input logic rne);
      logic inc;
      inc = rne & m[2] & (m[1] | m[0] | m[3]);
      return {1'b0, m[D-1:3]} + {{(FRACW+1){1'b0}}, inc};
   endfunction

   function automatic logic [W-1:0] ovf_f(input logic s, input logic rne);
      return rne ? {s, EXP_ONES, {FRACW{1'b0}}} : {s, EXP_MAXF, {FRACW{1'b1}}};
   endfunction

   logic advance;
   logic vld_p1_q, vld_p2_q, vld_p3_q;
   logic [W-1:0] result_q;
   logic [4:0]   flags_q;

   assign advance     = !vld_p3_q | outReady;
   assign inReady     = advance;
   assign outValid    = vld_p3_q;
   assign result      = result_q;
   assign statusFlags = flags_q;

   // ---- stage 1: specials, magnitude sort, alignment ----
   logic             sa, sb, nan_a, nan_b, inf_a, inf_b, snan_a, snan_b, a_big;
   logic [EXPW-1:0]  ea, eb, ea_eff, eb_eff;
   logic [FRACW-1:0] fa, fb;
   logic [D-1:0]     siga, sigb;

   assign {sa, ea, fa} = fpuIn1;
   assign sb           = fpuIn2[W-1] ^ op;
   assign {eb, fb}     = fpuIn2[W-2:0];
   assign nan_a  = (ea == EXP_ONES) && (fa != '0);
   assign nan_b  = (eb == EXP_ONES) && (fb != '0);
   assign inf_a  = (ea == EXP_ONES) && (fa == '0);
   assign inf_b  = (eb == EXP_ONES) && (fb == '0);
   assign snan_a = nan_a && !fa[FRACW-1];
   assign snan_b = nan_b && !fb[FRACW-1];
   assign ea_eff = (ea == '0) ? EXPW'(1) : ea;
   assign eb_eff = (eb == '0) ? EXPW'(1) : eb;
   assign siga   = {ea != '0, fa, 3'b000};
   assign sigb   = {eb != '0, fb, 3'b000};
   assign a_big  = {ea, fa} >= {eb, fb};

   logic            spec_p1_d, nv_p1_d, sign_p1_d;
   logic [W-1:0]    sres_p1_d;
   logic [EXPW-1:0] exp_p1_d;
   logic [D-1:0]    big_p1_d, sml_p1_d;

   always_comb begin
      spec_p1_d = 1'b0;
      nv_p1_d   = 1'b0;
      sres_p1_d = QNAN;
      sign_p1_d = sa;
      exp_p1_d  = ea_eff;
      big_p1_d  = siga;
      sml_p1_d  = '0;
      if (nan_a || nan_b || (inf_a && inf_b && (sa != sb))) begin
         spec_p1_d = 1'b1;
         nv_p1_d   = snan_a || snan_b || !(nan_a || nan_b);
      end else if (inf_a || inf_b) begin
         spec_p1_d = 1'b1;
         sres_p1_d = {inf_a ? sa : sb, EXP_ONES, {FRACW{1'b0}}};
      end
      if (a_big) begin
         sml_p1_d = align_f(sigb, ea_eff - eb_eff);
      end else begin
         sign_p1_d = sb;
         exp_p1_d  = eb_eff;
         big_p1_d  = sigb;
         sml_p1_d  = align_f(siga, eb_eff - ea_eff);
      end
   end

   logic            spec_p1_q, nv_p1_q, sign_p1_q, zs_p1_q, sub_p1_q, rne_p1_q;
   logic [W-1:0]    sres_p1_q;
   logic [EXPW-1:0] exp_p1_q;
   logic [D-1:0]    big_p1_q, sml_p1_q;

   // ---- stage 2: significand add/subtract ----
   logic [D:0] sum_p2_d;
   logic       sign_p2_d;

   assign sum_p2_d  = sub_p1_q ? ({1'b0, big_p1_q} - {1'b0, sml_p1_q})
                               : ({1'b0, big_p1_q} + {1'b0, sml_p1_q});
   assign sign_p2_d = (sum_p2_d == '0) ? zs_p1_q : sign_p1_q;

   logic            spec_p2_q, nv_p2_q, sign_p2_q, rne_p2_q;
   logic [W-1:0]    sres_p2_q;
   logic [EXPW-1:0] exp_p2_q;
   logic [D:0]      sum_p2_q;

   // ---- stage 3: normalise, round, overflow ----
   logic [D-1:0]     m_n;
   logic [EW-1:0]    e_n, e_r, fld;
   logic [FRACW+1:0] mant;
   int unsigned      sh;
   logic             of, uf, nx;
   logic [W-1:0]     res_d;
   logic [4:0]       flags_d;

   always_comb begin
      e_n  = EW'(exp_p2_q);
      m_n  = sum_p2_q[D-1:0];
      sh   = 0;
      if (sum_p2_q[D]) begin
         m_n = {sum_p2_q[D:2], |sum_p2_q[1:0]};
         e_n = e_n + EW'(1);
      end else begin
         // Left shift stops at exponent 1 so the result lands as a subnormal.
         sh = lzc_f(sum_p2_q[D-1:0]);
         if (sh > 32'(exp_p2_q) - 1) sh = 32'(exp_p2_q) - 1;
         m_n = m_n << sh;
         e_n = e_n - EW'(sh);
      end
      mant = round_f(m_n, rne_p2_q);
      e_r  = e_n;
      if (mant[FRACW+1]) begin
         mant = mant >> 1;
         e_r  = e_r + EW'(1);
      end
      fld     = mant[FRACW] ? e_r : '0;
      nx      = |m_n[2:0];
      of      = fld >= EW'(EXP_ONES);
      res_d   = {sign_p2_q, fld[EXPW-1:0], mant[FRACW-1:0]};
      if (of) begin
         res_d = ovf_f(sign_p2_q, rne_p2_q);
         nx    = 1'b1;
      end
      uf      = (fld == '0) && nx;
      flags_d = {1'b0, 1'b0, of, uf, nx};
      if (spec_p2_q) begin
         res_d   = sres_p2_q;
         flags_d = {nv_p2_q, 4'b0000};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1_q <= 1'b0;
         vld_p2_q <= 1'b0;
         vld_p3_q <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else if (advance) begin
         vld_p1_q <= inValid;
         vld_p2_q <= vld_p1_q;
         vld_p3_q <= vld_p2_q;
         if (vld_p2_q) begin
            result_q <= res_d;
            flags_q  <= flags_d;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (advance) begin
         spec_p1_q <= spec_p1_d;
         nv_p1_q   <= nv_p1_d;
         sres_p1_q <= sres_p1_d;
         sign_p1_q <= sign_p1_d;
         zs_p1_q   <= sa & sb;
         sub_p1_q  <= sa ^ sb;
         rne_p1_q  <= !rndMode;
         exp_p1_q  <= exp_p1_d;
         big_p1_q  <= big_p1_d;
         sml_p1_q  <= sml_p1_d;
         spec_p2_q <= spec_p1_q;
         nv_p2_q   <= nv_p1_q;
         sres_p2_q <= sres_p1_q;
         sign_p2_q <= sign_p2_d;
         rne_p2_q  <= rne_p1_q;
         exp_p2_q  <= exp_p1_q;
         sum_p2_q  <= sum_p2_d;
      end
   end
endmodule

// File: tb/tb_fpu_addsub_pipe.sv
// Bench for fpu_addsub_pipe in FP16: directed vectors, handshake stalls, reset and random traffic
// against an exact-integer rounding model.
module tb_fpu_addsub_pipe;
   logic        clk = 1'b0, rst_n = 1'b0, inValid = 1'b0, op = 1'b0, rndMode = 1'b0, outReady = 1'b1;
   logic [15:0] fpuIn1 = '0, fpuIn2 = '0;
   logic        inReady, outValid;
   logic [15:0] result;
   logic [4:0]  statusFlags;
   int          n_cmp = 0, n_fail = 0;

   fpu_addsub_pipe #(.EXPW(5), .FRACW(10)) dut (
      .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
      .fpuIn1(fpuIn1), .fpuIn2(fpuIn2), .op(op), .rndMode(rndMode),
      .outValid(outValid), .outReady(outReady), .result(result), .statusFlags(statusFlags)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Value in units of 2^-24 (the FP16 subnormal quantum), so every FP16 value is an exact integer.
   function automatic longint dec(input logic [15:0] x);
      longint m;
      int     e;
      e = int'(x[14:10]);
      m = longint'(x[9:0]);
      if (e != 0) m = (m + 1024) <<< (e - 1);
      return x[15] ? -m : m;
   endfunction

   function automatic void ref_model(input logic [15:0] a, input logic [15:0] b, input logic o,
                                     input logic rtz, output logic [15:0] r, output logic [4:0] f);
      logic   sa, sbe, nan_a, nan_b, inf_a, inf_b, s, nx, uf;
      longint v, mag, n, rem, q;
      int     e;
      logic [4:0] ef;
      sa    = a[15];
      sbe   = b[15] ^ o;
      nan_a = (a[14:10] == 5'h1F) && (a[9:0] != 0);
      nan_b = (b[14:10] == 5'h1F) && (b[9:0] != 0);
      inf_a = (a[14:10] == 5'h1F) && (a[9:0] == 0);
      inf_b = (b[14:10] == 5'h1F) && (b[9:0] == 0);
      r = 16'h0000;
      f = 5'b00000;
      if (nan_a || nan_b || (inf_a && inf_b && sa != sbe)) begin
         r = 16'h7E00;
         f = {(nan_a && !a[9]) || (nan_b && !b[9]) || !(nan_a || nan_b), 4'b0000};
         return;
      end
      if (inf_a) begin r = {sa, 15'h7C00}; return; end
      if (inf_b) begin r = {sbe, 15'h7C00}; return; end
      v = dec(a) + (o ? -dec(b) : dec(b));
      if (v == 0) begin r = {sa & sbe, 15'h0000}; return; end
      s   = v < 0;
      mag = s ? -v : v;
      e   = 1;
      while ((mag >>> (e - 1)) >= 2048) e++;
      q   = longint'(1) <<< (e - 1);
      n   = mag >>> (e - 1);
      rem = mag - (n <<< (e - 1));
      nx  = rem != 0;
      if (!rtz && (2 * rem > q || (2 * rem == q && (n & 1) == 1))) n++;
      if (n == 2048) begin n = 1024; e++; end
      if (e >= 31) begin
         f = 5'b00101;
         r = rtz ? {s, 15'h7BFF} : {s, 15'h7C00};
         return;
      end
      if (n < 1024) begin
         ef = 5'd0;
         r  = {s, ef, 10'(n)};
      end else begin
         ef = 5'(e);
         r  = {s, ef, 10'(n - 1024)};
      end
      uf = (ef == 0) && nx;
      f  = {3'b000, uf, nx};
   endfunction

   function automatic logic [15:0] rand_fp();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 7))
         0: x[14:10] = 5'h1F;
         1: x[14:10] = 5'h00;
         2: x[14:10] = 5'h1E;
         default: ;
      endcase
      return x;
   endfunction

   task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic o, input logic r,
                          output logic [15:0] res, output logic [4:0] fl, output int lat);
      @(negedge clk);
      fpuIn1 = a; fpuIn2 = b; op = o; rndMode = r; inValid = 1'b1; outReady = 1'b1;
      @(negedge clk);
      inValid = 1'b0;
      lat = 1;
      while (!outValid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      res = result;
      fl  = statusFlags;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; inValid = 1'b0; outReady = 1'b0;
      repeat (3) @(negedge clk);
      n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL rst_outValid: got %b, required 0", outValid); end
      n_cmp++; if (result !== 16'h0) begin n_fail++; $display("FAIL rst_result: got %h, required 0000", result); end
      n_cmp++; if (statusFlags !== 5'h0) begin n_fail++; $display("FAIL rst_flags: got %b, required 00000", statusFlags); end
      rst_n = 1'b1;
      #1;
      n_cmp++; if (inReady !== 1'b1) begin n_fail++; $display("FAIL rst_inReady: got %b, required 1", inReady); end
      outReady = 1'b1;
   endtask

   task automatic test_basic();
      logic [54:0] tbl [18] = '{
         {16'h3C00, 16'h4000, 1'b0, 1'b0, 16'h4200, 5'h00},
         {16'h3C00, 16'h3C00, 1'b1, 1'b0, 16'h0000, 5'h00},
         {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 5'h00},
         {16'h3C00, 16'h1000, 1'b0, 1'b0, 16'h3C00, 5'h01},
         {16'h3C01, 16'h1000, 1'b0, 1'b0, 16'h3C02, 5'h01},
         {16'h3C01, 16'h1000, 1'b0, 1'b1, 16'h3C01, 5'h01},
         {16'h7BFF, 16'h7BFF, 1'b0, 1'b0, 16'h7C00, 5'h05},
         {16'h7BFF, 16'h7BFF, 1'b0, 1'b1, 16'h7BFF, 5'h05},
         {16'h7C00, 16'h7C00, 1'b1, 1'b0, 16'h7E00, 5'h10},
         {16'h7D00, 16'h3C00, 1'b0, 1'b0, 16'h7E00, 5'h10},
         {16'h7C00, 16'h3C00, 1'b0, 1'b0, 16'h7C00, 5'h00},
         {16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 5'h00},
         {16'h0400, 16'h0001, 1'b1, 1'b0, 16'h03FF, 5'h00},
         {16'h0001, 16'h8000, 1'b0, 1'b0, 16'h0001, 5'h00},
         {16'h3C00, 16'h3C00, 1'b1, 1'b1, 16'h0000, 5'h00},
         {16'h8000, 16'h0000, 1'b1, 1'b0, 16'h8000, 5'h00},
         {16'h03FF, 16'h0001, 1'b0, 1'b0, 16'h0400, 5'h00},
         {16'h3C01, 16'h3C00, 1'b1, 1'b0, 16'h1400, 5'h00}};
      logic [15:0] a, b, er, res;
      logic [4:0]  ef, fl;
      logic        o, r;
      int          lat;
      for (int i = 0; i < 18; i++) begin
         {a, b, o, r, er, ef} = tbl[i];
         run_one(a, b, o, r, res, fl, lat);
         n_cmp++; if (res !== er) begin n_fail++; $display("FAIL basic_res[%0d] %h%s%h rtz=%b: got %h, required %h", i, a, o ? "-" : "+", b, r, res, er); end
         n_cmp++; if (fl !== ef) begin n_fail++; $display("FAIL basic_flags[%0d]: got %b, required %b", i, fl, ef); end
         n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d, required 3", i, lat); end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] qr[$], hold_r, er;
      logic [4:0]  qf[$], hold_f, ef;
      bit          pend = 0, holding = 0;
      int          sent = 0, got = 0;
      for (int c = 0; c < 40 && got < 6; c++) begin
         @(negedge clk);
         outReady = !(c >= 4 && c <= 7);
         if (!pend) begin
            if (sent < 6) begin
               fpuIn1 = rand_fp(); fpuIn2 = rand_fp();
               op = 1'($urandom); rndMode = 1'($urandom);
               inValid = 1'b1; pend = 1;
            end else inValid = 1'b0;
         end
         #1;
         if (holding) begin
            n_cmp++;
            if (outValid !== 1'b1 || result !== hold_r || statusFlags !== hold_f) begin
               n_fail++; $display("FAIL b2b_hold c=%0d: got v=%b %h/%b, required v=1 %h/%b", c, outValid, result, statusFlags, hold_r, hold_f);
            end
         end
         holding = 0;
         if (outValid && !outReady) begin
            n_cmp++; if (inReady !== 1'b0) begin n_fail++; $display("FAIL b2b_inReady c=%0d: got %b, required 0", c, inReady); end
            holding = 1; hold_r = result; hold_f = statusFlags;
         end
         if (outValid && outReady) begin
            n_cmp++;
            if (qr.size() == 0) begin
               n_fail++; $display("FAIL b2b_extra c=%0d: got result %h, required none", c, result);
            end else begin
               er = qr.pop_front(); ef = qf.pop_front();
               if (result !== er || statusFlags !== ef) begin
                  n_fail++; $display("FAIL b2b_out #%0d: got %h/%b, required %h/%b", got, result, statusFlags, er, ef);
               end
            end
            got++;
         end
         if (inValid && inReady) begin
            ref_model(fpuIn1, fpuIn2, op, rndMode, er, ef);
            qr.push_back(er); qf.push_back(ef);
            sent++; pend = 0;
         end
      end
      inValid = 1'b0; outReady = 1'b1;
      n_cmp++; if (got != 6) begin n_fail++; $display("FAIL b2b_count: got %0d results, required 6", got); end
      repeat (5) begin
         @(negedge clk);
         n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL b2b_dup: got outValid %b, required 0", outValid); end
      end
   endtask

   task automatic test_random();
      logic [15:0] qr[$], er;
      logic [4:0]  qf[$], ef;
      bit          pend = 0;
      int          sent = 0, got = 0, n_ops = 400;
      for (int c = 0; c < 5000 && got < n_ops; c++) begin
         @(negedge clk);
         outReady = ($urandom_range(0, 9) < 7);
         if (!pend) begin
            if (sent < n_ops && $urandom_range(0, 4) != 0) begin
               fpuIn1 = rand_fp(); fpuIn2 = rand_fp();
               if ($urandom_range(0, 3) == 0) fpuIn2[14:10] = fpuIn1[14:10];
               op = 1'($urandom); rndMode = 1'($urandom);
               inValid = 1'b1; pend = 1;
            end else inValid = 1'b0;
         end
         #1;
         if (outValid && outReady) begin
            n_cmp++;
            if (qr.size() == 0) begin
               n_fail++; $display("FAIL rand_extra: got result %h, required none", result);
            end else begin
               er = qr.pop_front(); ef = qf.pop_front();
               if (result !== er || statusFlags !== ef) begin
                  n_fail++; $display("FAIL rand_out #%0d: got %h/%b, required %h/%b", got, result, statusFlags, er, ef);
               end
            end
            got++;
         end
         if (inValid && inReady) begin
            ref_model(fpuIn1, fpuIn2, op, rndMode, er, ef);
            qr.push_back(er); qf.push_back(ef);
            sent++; pend = 0;
         end
      end
      inValid = 1'b0; outReady = 1'b1;
      n_cmp++; if (got != n_ops) begin n_fail++; $display("FAIL rand_count: got %0d results, required %0d", got, n_ops); end
   endtask

   task automatic test_reset_inflight();
      logic [15:0] res;
      logic [4:0]  fl;
      int          lat;
      outReady = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         fpuIn1 = 16'h3C00 + 16'(c); fpuIn2 = 16'h4000; op = 1'b0; rndMode = 1'b0; inValid = 1'b1;
      end
      @(negedge clk);
      inValid = 1'b0;
      n_cmp++; if (outValid !== 1'b1) begin n_fail++; $display("FAIL inflight_pre: got outValid %b, required 1", outValid); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL inflight_async: got outValid %b, required 0", outValid); end
      n_cmp++; if (result !== 16'h0 || statusFlags !== 5'h0) begin n_fail++; $display("FAIL inflight_clear: got %h/%b, required 0000/00000", result, statusFlags); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1; outReady = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         n_cmp++; if (outValid !== 1'b0) begin n_fail++; $display("FAIL inflight_stale c=%0d: got outValid %b result %h, required 0", c, outValid, result); end
      end
      run_one(16'h3C00, 16'h4000, 1'b1, 1'b0, res, fl, lat);
      n_cmp++; if (res !== 16'hBC00 || fl !== 5'h0) begin n_fail++; $display("FAIL inflight_recover: got %h/%b, required bc00/00000", res, fl); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_random();
      test_reset_inflight();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
